// File: rtl/seq_pkg.sv
// Shared types and defaults for the stage sequencer: FSM state encoding,
// parameter defaults and a constant-evaluable ceil(log2) helper.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int DEF_NUM_STAGES = 8;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_TIMEOUT    = 1024;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_next_stage.sv
// Finds the lowest set mask bit strictly above from_i, or the lowest set bit
// overall when from_zero_i is high.
module seq_next_stage
  import seq_pkg::*;
#(
  parameter  int NUM_STAGES = DEF_NUM_STAGES,
  localparam int IDX_W      = clog2(NUM_STAGES)
) (
  input  logic [NUM_STAGES-1:0] mask_i,
  input  logic [IDX_W-1:0]      from_i,
  input  logic                  from_zero_i,
  output logic                  found_o,
  output logic [IDX_W-1:0]      idx_o
);

  // Scanning downwards lets the last hit be the lowest qualifying index.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (mask_i[k] && (from_zero_i || (k > int'(from_i)))) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Run controller for the routing-decision pipeline: starts masked stages in
// ascending order and hands the single memory port to the stage being waited on.
module stage_sequencer
  import seq_pkg::*;
#(
  parameter  int NUM_STAGES = DEF_NUM_STAGES,
  parameter  int ADDR_W     = DEF_ADDR_W,
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int TIMEOUT    = DEF_TIMEOUT,
  localparam int IDX_W      = clog2(NUM_STAGES)
) (
  input  logic                         clock,
  input  logic                         nrst,
  input  logic                         en,
  input  logic                         go,
  input  logic [NUM_STAGES-1:0]        stage_mask,
  output logic [NUM_STAGES-1:0]        stg_start,
  input  logic [NUM_STAGES-1:0]        stg_done,
  input  logic [NUM_STAGES-1:0]        stg_abort,
  input  logic [NUM_STAGES*ADDR_W-1:0] stg_addr,
  input  logic [NUM_STAGES-1:0]        stg_wr_en,
  input  logic [NUM_STAGES*DATA_W-1:0] stg_wdata,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_wr_en,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         busy,
  output logic [IDX_W-1:0]             active_stage,
  output logic                         run_done,
  output logic                         run_aborted,
  output logic                         run_error,
  output logic [IDX_W-1:0]             err_stage
);

  localparam int CNT_W = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        active_q, active_d;
  logic [IDX_W-1:0]        err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   mask_q, mask_d;
  logic                    done_q, done_d;
  logic                    abort_q, abort_d;
  logic                    error_q, error_d;

  logic                    nxt_found;
  logic [IDX_W-1:0]        nxt_idx;
  logic                    done_sel;
  logic                    abort_sel;

  // In IDLE the search runs over the live mask from bit 0; otherwise it looks
  // above the current owner in the mask latched at run start.
  seq_next_stage #(
    .NUM_STAGES (NUM_STAGES)
  ) u_next (
    .mask_i      ((state_q == IDLE) ? stage_mask : mask_q),
    .from_i      (active_q),
    .from_zero_i (state_q == IDLE),
    .found_o     (nxt_found),
    .idx_o       (nxt_idx)
  );

  assign done_sel  = stg_done[active_q];
  assign abort_sel = stg_abort[active_q];

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      active_q <= '0;
      err_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      error_q  <= error_d;
    end
  end

  // With en low every register, pending pulses included, simply holds.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    done_d   = en ? 1'b0 : done_q;
    abort_d  = en ? 1'b0 : abort_q;
    error_d  = en ? 1'b0 : error_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            mask_d = stage_mask;
            if (nxt_found) begin
              active_d = nxt_idx;
              state_d  = START;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        START: begin
          cnt_d   = '0;
          state_d = WAIT;
        end
        WAIT: begin
          if (done_sel) begin
            if (abort_sel) begin
              abort_d = 1'b1;
              state_d = IDLE;
            end else if (nxt_found) begin
              active_d = nxt_idx;
              state_d  = START;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            error_d = 1'b1;
            err_d   = active_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign stg_start    = (en && (state_q == START)) ? (NUM_STAGES'(1) << active_q) : '0;
  assign busy         = (state_q != IDLE);
  assign active_stage = active_q;
  assign err_stage    = err_q;
  assign run_done     = done_q & en;
  assign run_aborted  = abort_q & en;
  assign run_error    = error_q & en;

  assign mem_addr  = stg_addr[int'(active_q) * ADDR_W +: ADDR_W];
  assign mem_wdata = stg_wdata[int'(active_q) * DATA_W +: DATA_W];
  assign mem_wr_en = en && (state_q == WAIT) && stg_wr_en[active_q];

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomised directed bench for stage_sequencer: each run is predicted from the
// sequencing rules (start/decision cycles per stage) and compared every cycle.
module tb_stage_sequencer;

  localparam int TIMEOUT = 16;

  logic         clock = 1'b0;
  logic         nrst;
  logic         en;
  logic         go;
  logic [7:0]   stage_mask;
  logic [7:0]   stg_start;
  logic [7:0]   stg_done;
  logic [7:0]   stg_abort;
  logic [127:0] stg_addr;
  logic [7:0]   stg_wr_en;
  logic [127:0] stg_wdata;
  logic [15:0]  mem_addr;
  logic         mem_wr_en;
  logic [15:0]  mem_wdata;
  logic         busy;
  logic [2:0]   active_stage;
  logic         run_done;
  logic         run_aborted;
  logic         run_error;
  logic [2:0]   err_stage;

  int nCmp = 0;
  int nFail = 0;

  logic [7:0] cfgMask;
  logic [7:0] cfgAbort;
  logic [7:0] cfgNever;
  int         cfgDelay [8];
  int         cfgWinStage;
  int         cfgWinOff;
  int         cfgWinLen;
  logic       cfgB2b;
  logic [7:0] cfgNextMask;
  logic       cfgSkip;
  int         expActive;
  int         expErr;

  stage_sequencer #(
    .NUM_STAGES (8),
    .ADDR_W     (16),
    .DATA_W     (16),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock        (clock),
    .nrst         (nrst),
    .en           (en),
    .go           (go),
    .stage_mask   (stage_mask),
    .stg_start    (stg_start),
    .stg_done     (stg_done),
    .stg_abort    (stg_abort),
    .stg_addr     (stg_addr),
    .stg_wr_en    (stg_wr_en),
    .stg_wdata    (stg_wdata),
    .mem_addr     (mem_addr),
    .mem_wr_en    (mem_wr_en),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .active_stage (active_stage),
    .run_done     (run_done),
    .run_aborted  (run_aborted),
    .run_error    (run_error),
    .err_stage    (err_stage)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setDefaults(input logic [7:0] mask, input int delay);
    cfgMask     = mask;
    cfgAbort    = 8'h00;
    cfgNever    = 8'h00;
    for (int k = 0; k < 8; k++) cfgDelay[k] = delay;
    cfgWinStage = -1;
    cfgWinOff   = 0;
    cfgWinLen   = 0;
    cfgB2b      = 1'b0;
    cfgNextMask = 8'h00;
  endtask

  task automatic randomDelays();
    for (int k = 0; k < 8; k++) cfgDelay[k] = int'($urandom_range(4, 1));
  endtask

  // One run: predict start/decision cycles from the rules, then play the stages.
  task automatic applyStimulus();
    int startC [8];
    int decC [8];
    int seenC [8];
    int t, rel, endC, endType, errS, winLo, winHi, c0;
    logic [7:0] expStart;
    logic inWait;
    logic expMemWr;
    t = 1; endC = -1; endType = 0; errS = 0;
    for (int k = 0; k < 8; k++) begin
      startC[k] = -1; decC[k] = -1; seenC[k] = -1;
    end
    for (int k = 0; k < 8; k++) begin
      if (!cfgMask[k]) continue;
      startC[k] = t;
      if (cfgNever[k]) begin
        rel = TIMEOUT + ((k == cfgWinStage) ? cfgWinLen : 0);
        decC[k] = t + rel;
        endType = 2; errS = k; endC = decC[k] + 1;
        break;
      end
      rel = cfgDelay[k];
      if (k == cfgWinStage && rel >= cfgWinOff && rel < cfgWinOff + cfgWinLen)
        rel = cfgWinOff + cfgWinLen;
      decC[k] = t + rel;
      t = decC[k] + 1;
      if (cfgAbort[k]) begin
        endType = 1; endC = t;
        break;
      end
    end
    if (endC < 0) endC = t;
    winLo = (cfgWinStage >= 0) ? startC[cfgWinStage] + cfgWinOff : -1;
    winHi = (cfgWinStage >= 0) ? winLo + cfgWinLen : -1;
    c0 = cfgSkip ? 1 : 0;

    for (int c = c0; c <= endC; c++) begin
      @(negedge clock);
      en = !(c >= winLo && c < winHi);
      if (c == 0) go = 1'b1;
      else if (c < endC) go = 1'($urandom_range(1, 0));
      else go = cfgB2b;
      if (c == 0) stage_mask = cfgMask;
      else if (c == endC && cfgB2b) stage_mask = cfgNextMask;
      else stage_mask = 8'($urandom());
      for (int k = 0; k < 8; k++) begin
        if (seenC[k] >= 0) begin
          stg_done[k]  = !cfgNever[k] && (c >= seenC[k] + cfgDelay[k]);
          stg_abort[k] = stg_done[k] && cfgAbort[k];
        end else if (!cfgMask[k]) begin
          stg_done[k]  = 1'($urandom());
          stg_abort[k] = 1'($urandom());
        end else begin
          stg_done[k]  = 1'b0;
          stg_abort[k] = 1'b0;
        end
      end
      stg_addr  = {$urandom(), $urandom(), $urandom(), $urandom()};
      stg_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      stg_wr_en = en ? 8'($urandom()) : 8'hFF;
      #1;
      expStart = 8'h00;
      inWait = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (startC[k] == c) begin
          expActive = k;
          expStart[k] = 1'b1;
        end
        if (startC[k] >= 0 && c > startC[k] && c <= decC[k]) inWait = 1'b1;
      end
      if (c == endC && endType == 2) expErr = errS;
      expMemWr = inWait && en && stg_wr_en[expActive];
      checkOutput("stg_start", 32'(stg_start), 32'(expStart));
      checkOutput("busy", 32'(busy), 32'(c >= 1 && c < endC));
      checkOutput("run_done", 32'(run_done), 32'(c == endC && endType == 0));
      checkOutput("run_aborted", 32'(run_aborted), 32'(c == endC && endType == 1));
      checkOutput("run_error", 32'(run_error), 32'(c == endC && endType == 2));
      checkOutput("active_stage", 32'(active_stage), 32'(expActive));
      checkOutput("err_stage", 32'(err_stage), 32'(expErr));
      checkOutput("mem_addr", 32'(mem_addr), 32'(stg_addr[expActive*16 +: 16]));
      checkOutput("mem_wdata", 32'(mem_wdata), 32'(stg_wdata[expActive*16 +: 16]));
      checkOutput("mem_wr_en", 32'(mem_wr_en), 32'(expMemWr));
      for (int k = 0; k < 8; k++) begin
        if (stg_start[k] && seenC[k] < 0) seenC[k] = c;
      end
    end
    cfgSkip = cfgB2b;
  endtask

  initial begin
    nrst = 1'b0; en = 1'b1; go = 1'b0; stage_mask = 8'h00;
    stg_done = 8'h00; stg_abort = 8'h00; stg_wr_en = 8'hFF;
    stg_addr = {8{16'hA5C3}}; stg_wdata = {8{16'h3C5A}};
    cfgSkip = 1'b0; expActive = 0; expErr = 0;
    $display("[TB] reset checks");
    repeat (3) @(negedge clock);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_start", 32'(stg_start), 32'd0);
    checkOutput("reset_active", 32'(active_stage), 32'd0);
    checkOutput("reset_err", 32'(err_stage), 32'd0);
    checkOutput("reset_pulses", 32'({run_done, run_aborted, run_error}), 32'd0);
    checkOutput("reset_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("reset_addr", 32'(mem_addr), 32'h0000A5C3);
    nrst = 1'b1;
    @(negedge clock);

    $display("[TB] full mask, done after 3 cycles");
    setDefaults(8'hFF, 3);
    applyStimulus();

    $display("[TB] sparse mask 1010_0100");
    setDefaults(8'b1010_0100, 3);
    applyStimulus();

    $display("[TB] abort from stage 3");
    setDefaults(8'hFF, 1); randomDelays(); cfgAbort = 8'h08;
    applyStimulus();

    $display("[TB] stage 1 never finishes");
    setDefaults(8'hFF, 1); randomDelays(); cfgNever = 8'h02;
    applyStimulus();

    $display("[TB] en low for 5 cycles in stage 4 wait");
    setDefaults(8'hFF, 1); randomDelays();
    cfgDelay[4] = 10; cfgWinStage = 4; cfgWinOff = 2; cfgWinLen = 5;
    applyStimulus();

    $display("[TB] en low during a timing-out stage");
    setDefaults(8'h10, 2); cfgNever = 8'h10;
    cfgWinStage = 4; cfgWinOff = 3; cfgWinLen = 5;
    applyStimulus();

    $display("[TB] empty mask");
    setDefaults(8'h00, 1);
    applyStimulus();

    $display("[TB] back-to-back runs");
    setDefaults(8'($urandom()) | 8'h01, 1); randomDelays();
    cfgB2b = 1'b1; cfgNextMask = 8'($urandom()) | 8'h80;
    applyStimulus();
    setDefaults(cfgNextMask, 1); randomDelays();
    applyStimulus();

    $display("[TB] reset asserted mid-run");
    @(negedge clock);
    go = 1'b1; stage_mask = 8'hFF; stg_done = 8'h00; stg_abort = 8'h00;
    @(negedge clock);
    go = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("midrun_busy_before", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    checkOutput("midrun_busy", 32'(busy), 32'd0);
    checkOutput("midrun_start", 32'(stg_start), 32'd0);
    checkOutput("midrun_active", 32'(active_stage), 32'd0);
    checkOutput("midrun_err", 32'(err_stage), 32'd0);
    checkOutput("midrun_pulses", 32'({run_done, run_aborted, run_error}), 32'd0);
    @(negedge clock);
    nrst = 1'b1;
    #1;
    checkOutput("midrun_pulses_after", 32'({run_done, run_aborted, run_error}), 32'd0);
    expActive = 0; expErr = 0;

    $display("[TB] randomised runs");
    for (int r = 0; r < 8; r++) begin
      setDefaults(8'($urandom()), 1); randomDelays();
      cfgAbort = 8'($urandom() & $urandom() & $urandom());
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised run controller and shared-memory port arbiter for the routing-decision pipeline. It starts NUM_STAGES processing stages one at a time via start/done handshakes and skips stages excluded by a per-run mask. It terminates a run early when a stage signals abort (e.g. forAggregation / not-forwarding) and flags stages that never finish. The single memory port is granted to the active stage only, so each stage keeps zero-latency access to `mem`.

## Interface
- NUM_STAGES, 8, number of stage channels (2..16)
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- TIMEOUT, 1024, max WAIT cycles per stage; 0 disables timeout
- IDX_W, derived = clog2(NUM_STAGES), stage index width (localparam)

- clock  in  1  single clock, rising edge
- nrst  in  1  asynchronous, active-low reset
- en  in  1  global enable; low freezes the sequencer
- go  in  1  start a run (sampled in IDLE only)
- stage_mask  in  NUM_STAGES  1 = run stage k; latched at accepted go
- stg_start  out  NUM_STAGES  one-hot, one-cycle start pulse
- stg_done  in  NUM_STAGES  stage k finished
- stg_abort  in  NUM_STAGES  qualifies stg_done[k]: end run after k
- stg_addr  in  NUM_STAGES*ADDR_W  per-stage address, stage k at [k*ADDR_W +: ADDR_W]
- stg_wr_en  in  NUM_STAGES  per-stage write enable
- stg_wdata  in  NUM_STAGES*DATA_W  per-stage write data
- mem_addr  out  ADDR_W  to memory
- mem_wr_en  out  1  to memory
- mem_wdata  out  DATA_W  to memory
- busy  out  1  run in progress
- active_stage  out  IDX_W  current owner index
- run_done  out  1  one-cycle pulse: run completed normally
- run_aborted  out  1  one-cycle pulse: run ended by stg_abort
- run_error  out  1  one-cycle pulse: stage timed out
- err_stage  out  IDX_W  index of last timed-out stage, held until next error

## Operation
- States: IDLE, START, WAIT.
- IDLE:
  - On go & en: latch stage_mask and search for the lowest set bit.
  - If a bit is found, load active_stage with it and go to START.
  - If the mask is 0, pulse run_done next cycle and stay in IDLE.
- START: stg_start[active_stage] = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT: only stg_done[active_stage] is observed; done/abort from other stages is ignored.
  - done & abort: pulse run_aborted and go to IDLE.
  - done & !abort:
    - If a higher masked stage exists, load the lowest such stage and go to START.
    - Otherwise pulse run_done and go to IDLE.
  - No done: the counter increments. When counter == TIMEOUT-1 (TIMEOUT≠0), pulse run_error, latch err_stage, go to IDLE.
- Memory mux (combinational):
  - In WAIT, mem_* = stage active_stage signals.
  - In IDLE/START, mem_addr = stg_addr[active_stage] and mem_wr_en = 0. mem_wdata passes through unchanged.
- en low:
  - No state, counter or index changes.
  - stg_start and the run_* pulses are held 0.
  - mem_wr_en is forced 0.
  - A START interrupted by en low re-issues its pulse when en returns.
- go while busy is ignored. A stage mask change mid-run has no effect.
- Stages must clear their done when they see stg_start. done is sampled only in WAIT, so a stale level during START is ignored.

## Timing
- Reset state:
  - IDLE, active_stage = 0, counter = 0, err_stage = 0.
  - stg_start = 0, busy = 0, all run_* = 0, mem_wr_en = 0.
- All control outputs are registered; the mem_* path is combinational (0 added latency).
- Run start: go accepted at edge n → stg_start pulse in cycle n+1 → WAIT from cycle n+2.
- Stage handoff: done seen at edge t → next stg_start in cycle t+1.
  - Minimum per-stage overhead is 1 cycle.
- Run end: the run_* pulse and busy = 0 appear in the cycle after the deciding edge.
- Back-to-back runs: go may be accepted in the same cycle that busy drops.
- busy = 1 in START and WAIT.
- Reset asserted mid-run: immediate return to IDLE and reset values. No done or abort pulse is produced.

## Structure
- Package `seq_pkg`: state enum (IDLE/START/WAIT), default parameter constants, clog2 helper.
- Sub-module `seq_next_stage`: combinational search for the lowest set mask bit strictly above a given index (or from 0), returns found + index. Used for both run start and handoff.

## Test plan
- Full mask (8'hFF), every stage answers done 3 cycles after start → stg_start one-hot walks 0..7, run_done single pulse, mem_wr_en follows only the owning stage.
- mask 8'b1010_0100 → starts only on stages 2, 5, 7; stages 0/1/3/4/6 never pulsed; active_stage 2→5→7.
- Stage 3 asserts done & abort (mask FF) → run_aborted pulse, busy = 0 next cycle, stages 4..7 never started.
- TIMEOUT = 16, stage 1 never done → run_error pulse exactly 16 WAIT cycles after its start, err_stage = 1, mem_wr_en = 0 afterwards.
- en low for 5 cycles during WAIT of stage 4 with stg_wr_en[4] = 1 → mem_wr_en = 0 throughout, counter frozen, resumes with no extra start pulse. Also a non-owner done, nrst pulsed mid-run, and a mask of 0 → run_done with no starts.
- go during busy, and done from a non-owner stage → both ignored.
